// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
//   state_e      : sequencer FSM states, 3-bit encoding
//   OP_*         : latched operation kind (multiply / divide)
//   SEL_*        : operand mux select values (MemMult aux regs / A,B regs)
//   sel_from_src : maps the "operands from memory regs" flag to a mux select
package mult_div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    WRITE = 3'd3,
    EXC   = 3'd4
  } state_e;

  localparam logic OP_MULT    = 1'b0;
  localparam logic OP_DIV     = 1'b1;

  localparam logic SEL_MEMAUX = 1'b0;
  localparam logic SEL_REG    = 1'b1;

  // src_mem = 1 picks the MemMultA/B registers, otherwise the A/B registers.
  function automatic logic sel_from_src(input logic src_mem);
    return src_mem ? SEL_MEMAUX : SEL_REG;
  endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// Down-counter that times the Mult/Div unit iterations.
// Ports:
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val this edge (takes priority over dec)
//   load_val   : initial count, i.e. iterations - 1
//   dec        : decrement by one this edge
//   zero       : count is zero (last iteration cycle)
module md_cycle_counter
  import mult_div_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the next value
  // is fully computed in the always_comb above.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mult_div_sequencer.sv
// Sequences the shared multiply/divide unit for Control on mult/div ops.
// One start request is accepted in IDLE; the op kind and operand source are
// latched, the unit is restarted (CLEAR), the fixed iteration count elapses
// (RUN), then Hi/Lo are loaded (WRITE). A divide by zero aborts from RUN into
// EXC, which raises div_zero and skips the Hi/Lo load.
// Ports:
//   clk, reset       : clock, synchronous active-high global reset
//   start            : op request, sampled only in IDLE
//   op_div, src_mem  : op kind / operand source, captured with start
//   zero_div         : divisor-is-zero flag from the Div unit
//   resetlocal       : one-cycle restart pulse to Mult/Div (CLEAR)
//   mult_div         : Hi/Lo result select, 0 = Mult, 1 = Div
//   mema_a, memb_b   : operand selects, 0 = MemMult regs, 1 = A/B regs
//   hi_load, lo_load : Hi/Lo register load enables (WRITE)
//   busy             : high in every state except IDLE
//   done             : Hi/Lo written this cycle
//   div_zero         : divide aborted on zero divisor this cycle
module mult_div_sequencer
  import mult_div_pkg::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op_div,
  input  logic src_mem,
  input  logic zero_div,
  output logic resetlocal,
  output logic mult_div,
  output logic mema_a,
  output logic memb_b,
  output logic hi_load,
  output logic lo_load,
  output logic busy,
  output logic done,
  output logic div_zero
);

  // The counter runs from N-1 down to 0, giving exactly N RUN cycles.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_e state_q, state_d;
  logic   op_q, op_d;
  logic   src_q, src_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  assign cnt_load_val = (op_q == OP_DIV) ? DIV_LOAD : MULT_LOAD;

  md_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    // NOTE: every signal written below gets a default here, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    resetlocal = 1'b0;
    hi_load    = 1'b0;
    lo_load    = 1'b0;
    done       = 1'b0;
    div_zero   = 1'b0;
    busy       = 1'b1;
    // Selects follow the latched op/source for the whole operation so that
    // operands cannot change under the running unit.
    mult_div   = op_q;
    mema_a     = sel_from_src(src_q);
    memb_b     = sel_from_src(src_q);

    unique case (state_q)
      IDLE: begin
        busy     = 1'b0;
        // Pass the live request through so the operands settle before CLEAR.
        mult_div = op_div;
        mema_a   = sel_from_src(src_mem);
        memb_b   = sel_from_src(src_mem);
        if (start) begin
          state_d = CLEAR;
          op_d    = op_div;
          src_d   = src_mem;
        end
      end
      CLEAR: begin
        resetlocal = 1'b1;
        cnt_load   = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        // Divide-by-zero wins over the final iteration.
        if ((op_q == OP_DIV) && zero_div) begin
          state_d = EXC;
        end else if (cnt_zero) begin
          state_d = WRITE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WRITE: begin
        // A reset arriving in this cycle discards the result.
        hi_load = ~reset;
        lo_load = ~reset;
        done    = ~reset;
        state_d = IDLE;
      end
      EXC: begin
        div_zero = ~reset;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
